// File: rtl/uart_rx_word_assembler.sv
// UART 8N1 receiver that decodes ASCII hex digits and assembles eight of them,
// most significant first, into a word with sticky ready and error flags.
module uart_rx_word_assembler #(
    parameter int DATA_WIDTH = 32,
    parameter int UART_Nbit  = 8,
    parameter int baudrate   = 9600,
    parameter int clk_freq   = 50000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  SerialDataIn,
    input  logic                  clr_rx_flag,
    input  logic                  clr_err_flag,
    output logic [DATA_WIDTH-1:0] UART_word,
    output logic [DATA_WIDTH-1:0] Rx_flag_out,
    output logic [DATA_WIDTH-1:0] Err_flag_out
);

    localparam int BIT_TICKS = clk_freq / baudrate;
    localparam int CNT_W     = $clog2(BIT_TICKS);
    localparam int BIT_W     = $clog2(UART_Nbit);

    localparam logic [CNT_W-1:0] TICK_LAST  = CNT_W'(BIT_TICKS - 1);
    localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(BIT_TICKS / 2 - 1);
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(UART_Nbit - 1);
    localparam logic [3:0]       DIGIT_LAST = 4'(DATA_WIDTH / 4 - 1);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StStart = 2'd1;
    localparam logic [1:0] StData  = 2'd2;
    localparam logic [1:0] StStop  = 2'd3;

    logic [1:0]            sync_q;
    logic                  rx_s;
    logic [1:0]            state_q, state_d;
    logic [CNT_W-1:0]      tick_q, tick_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [UART_Nbit-1:0]  data_q, data_d;
    logic [UART_Nbit-1:0]  char_q, char_d;
    logic                  char_stb_q, char_stb_d;
    logic                  framing_set;

    logic [7:0]            ch;
    logic                  digit_ok;
    logic                  ignore_ch;
    logic [3:0]            nibble;

    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] word_q, word_d;
    logic [3:0]            count_q, count_d;
    logic                  ready_q, ready_d;
    logic                  framing_q, framing_d;
    logic                  bad_q, bad_d;
    logic                  overrun_q, overrun_d;

    assign rx_s = sync_q[1];

    always_comb begin
        state_d     = state_q;
        tick_d      = tick_q;
        bit_d       = bit_q;
        data_d      = data_q;
        char_d      = char_q;
        char_stb_d  = 1'b0;
        framing_set = 1'b0;
        case (state_q)
            StIdle: begin
                if (!rx_s) begin
                    state_d = StStart;
                    tick_d  = '0;
                end
            end
            StStart: begin
                if (tick_q == HALF_LAST) begin
                    // Line back high at mid start bit means a glitch, not a start.
                    state_d = rx_s ? StIdle : StData;
                    tick_d  = '0;
                    bit_d   = '0;
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            StData: begin
                if (tick_q == TICK_LAST) begin
                    tick_d = '0;
                    data_d = {rx_s, data_q[UART_Nbit-1:1]};
                    if (bit_q == BIT_LAST) begin
                        state_d = StStop;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            default: begin
                if (tick_q == TICK_LAST) begin
                    state_d = StIdle;
                    tick_d  = '0;
                    if (rx_s) begin
                        char_stb_d = 1'b1;
                        char_d     = data_q;
                    end else begin
                        framing_set = 1'b1;
                    end
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        ch        = 8'(char_q);
        digit_ok  = 1'b0;
        ignore_ch = 1'b0;
        nibble    = 4'd0;
        if (ch >= 8'h30 && ch <= 8'h39) begin
            digit_ok = 1'b1;
            nibble   = ch[3:0];
        end else if ((ch >= 8'h41 && ch <= 8'h46) || (ch >= 8'h61 && ch <= 8'h66)) begin
            digit_ok = 1'b1;
            nibble   = ch[3:0] + 4'd9;
        end else if (ch == 8'h0D || ch == 8'h0A) begin
            ignore_ch = 1'b1;
        end
    end

    // Clears apply first so a set in the same cycle wins.
    always_comb begin
        ready_d   = ready_q & clr_rx_flag;
        framing_d = (framing_q & clr_err_flag) | framing_set;
        bad_d     = bad_q & clr_err_flag;
        overrun_d = overrun_q & clr_err_flag;
        word_d    = word_q;
        shift_d   = shift_q;
        count_d   = count_q;
        if (char_stb_q) begin
            if (digit_ok) begin
                shift_d = {shift_q[DATA_WIDTH-5:0], nibble};
                if (count_q == DIGIT_LAST) begin
                    count_d = 4'd0;
                    if (!ready_d) begin
                        word_d  = {shift_q[DATA_WIDTH-5:0], nibble};
                        ready_d = 1'b1;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end else begin
                    count_d = count_q + 4'd1;
                end
            end else if (!ignore_ch) begin
                bad_d   = 1'b1;
                shift_d = '0;
                count_d = 4'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q     <= 2'b11;
            state_q    <= StIdle;
            tick_q     <= '0;
            bit_q      <= '0;
            data_q     <= '0;
            char_q     <= '0;
            char_stb_q <= 1'b0;
            shift_q    <= '0;
            word_q     <= '0;
            count_q    <= 4'd0;
            ready_q    <= 1'b0;
            framing_q  <= 1'b0;
            bad_q      <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], SerialDataIn};
            state_q    <= state_d;
            tick_q     <= tick_d;
            bit_q      <= bit_d;
            data_q     <= data_d;
            char_q     <= char_d;
            char_stb_q <= char_stb_d;
            shift_q    <= shift_d;
            word_q     <= word_d;
            count_q    <= count_d;
            ready_q    <= ready_d;
            framing_q  <= framing_d;
            bad_q      <= bad_d;
            overrun_q  <= overrun_d;
        end
    end

    assign UART_word    = word_q;
    assign Rx_flag_out  = {{(DATA_WIDTH-1){1'b0}}, ready_q};
    assign Err_flag_out = {{(DATA_WIDTH-3){1'b0}}, overrun_q, bad_q, framing_q};

endmodule

// File: doc/uart_rx_word_assembler.md
# uart_rx_word_assembler

Receive-side counterpart of the UART word transmitter. It deserializes 8N1 UART characters from `SerialDataIn` and decodes each ASCII hex digit to a nibble. It assembles eight digits, most significant first, into one 32-bit word, which it presents to the MIPS memory-mapped I/O with a sticky ready flag and an error/status word. It sits beside the TX controller on the same baud parameters, so a word sent as "1234ABCD" by the peer arrives as 0x1234ABCD.

## Interface
- `DATA_WIDTH`, 32, width of the word and of the flag outputs.
- `UART_Nbit`, 8, data bits per character.
- `baudrate`, 9600, line rate.
- `clk_freq`, 50000000, clock frequency in Hz. `BIT_TICKS = clk_freq/baudrate` (integer divide).
- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high reset.
- `SerialDataIn` input 1: UART line, idle high, asynchronous to `clk`.
- `clr_rx_flag` input 1: active-low. 0 clears `Rx_flag_out[0]`.
- `clr_err_flag` input 1: active-low. 0 clears `Err_flag_out[2:0]`.
- `UART_word` output 32: last completed word.
- `Rx_flag_out` output 32: `{31'b0, word_ready}`.
- `Err_flag_out` output 32: `{29'b0, overrun, bad_char, framing}`.

## Operation
- Input is a 2-flop synchronizer. The line FSM sees only the synchronized value.
- Line FSM states:
  - IDLE: wait for a low level.
  - START: count `BIT_TICKS/2`. If the line is still low, go to DATA. Otherwise return to IDLE; this is glitch reject.
  - DATA: every `BIT_TICKS`, sample one bit, LSB first, `UART_Nbit` bits.
  - STOP: after `BIT_TICKS`, sample. 1 gives a valid character. 0 sets `framing` and discards the character. Both go to IDLE.
- Decode:
  - 0x30–0x39 → 0–9.
  - 0x41–0x46 and 0x61–0x66 → 10–15.
  - 0x0D and 0x0A are ignored: no count change, no error.
  - Any other character sets `bad_char` and clears `shift_reg` and `char_count` (resynchronization).
- Assembly: for a valid digit, `shift_reg <= {shift_reg[27:0], nibble}` and `char_count++` (4-bit). When the 8th digit is accepted:
  - If `word_ready`=0: `UART_word <= {shift_reg[27:0], nibble}` and `word_ready <= 1`.
  - If `word_ready`=1: set `overrun`; `UART_word` keeps its old value.
  - In both cases `char_count` goes to 0.
- Clearing flags does not affect `shift_reg` or `char_count`. A partial word survives a flag clear.
- Simultaneous events:
  - Set and clear of the same flag in one cycle: set wins.
  - `overrun` and `word_ready` are evaluated in the same cycle as the `clr_rx_flag`=0 sample. The clear applies first, so the word loads and no overrun is flagged.
- Reset mid-character or mid-word: everything is abandoned. The FSM goes to IDLE, `char_count`=0, and a partial word is lost.

## Timing
- Reset values: `UART_word`=0, `Rx_flag_out`=0, `Err_flag_out`=0, `shift_reg`=0, `char_count`=0, FSM=IDLE.
- Input latency is 2 clocks through the synchronizer.
- Sample points are about `BIT_TICKS/2 + k*BIT_TICKS` after the synchronized falling edge, for k = 1..8 data bits and k = 9 for stop.
- `UART_word` and `word_ready` update on the clock edge after the 8th character's stop-bit sample. They are valid together; no intermediate value is visible.
- Flags and errors are sticky until their active-low clear is sampled low.
- The receiver accepts back-to-back characters. IDLE re-arms in the cycle after the stop sample, so the next start bit may begin at the nominal stop-bit end.

## Test plan
Bench uses `baudrate`=5, `clk_freq`=50, so `BIT_TICKS`=10.
- Send "1234ABCD" → `UART_word`=0x1234ABCD, `Rx_flag_out`=0x1 one clock after the last stop sample, `Err_flag_out`=0.
- Send "dead\r\nbeef", then pulse `clr_rx_flag`=0 → `UART_word`=0xDEADBEEF with no error, then `Rx_flag_out`=0.
- Send "12G" then "00000005" → `Err_flag_out`=0x2 after 'G'; `UART_word`=0x00000005, so the partial "12" is discarded.
- Character 0x31 with stop bit driven 0 → `Err_flag_out`=0x1 and `char_count` unchanged. A 3-clock low glitch on idle → no character received.
- Complete "11111111" without clearing, then send "22222222" → `UART_word` stays 0x11111111 and `Err_flag_out`=0x4. Repeat with `clr_rx_flag`=0 on the completion cycle → `UART_word`=0x22222222, `Rx_flag_out`=0x1, no overrun.
- Assert `reset` after 4 digits and in mid-character, then send "CAFEF00D" → all outputs 0 during reset, then `UART_word`=0xCAFEF00D.
